id_stage_pipe: RTL and testbench

ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

---
 rtl/mips_pkg.sv | 34 +++
 rtl/id_decoder.sv | 54 +++++
 rtl/id_stage_pipe.sv | 172 +++++++++++++++++
 tb/tb_id_stage_pipe.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcode constants and decode control bundle for the ID stage
package mips_pkg;

    localparam int OPCODE_W = 6;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'h0C;

    typedef enum logic [1:0] {
        DST_NONE = 2'd0,
        DST_RT   = 2'd1,
        DST_RD   = 2'd2
    } dst_sel_e;

    typedef enum logic {
        IMM_SEXT = 1'b0,
        IMM_ZEXT = 1'b1
    } imm_sel_e;

    typedef struct packed {
        logic     valid;
        logic     mem_read;
        logic     mem_write;
        logic     reg_write;
        logic     alu_src;
        logic     use_rt;
        dst_sel_e dst_sel;
    } ctrl_t;

endpackage

// File: rtl/id_decoder.sv
// rtl/id_decoder.sv - combinational opcode decode into control bundle and immediate select
module id_decoder
    import mips_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode_i,
    output ctrl_t               ctrl_o,
    output imm_sel_e            imm_sel_o
);

    always_comb begin
        ctrl_o    = '0;
        imm_sel_o = IMM_SEXT;
        case (opcode_i)
            OP_RTYPE: begin
                ctrl_o.valid     = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.use_rt    = 1'b1;
                ctrl_o.dst_sel   = DST_RD;
            end
            OP_LW: begin
                ctrl_o.valid     = 1'b1;
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.dst_sel   = DST_RT;
            end
            OP_SW: begin
                ctrl_o.valid     = 1'b1;
                ctrl_o.mem_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.use_rt    = 1'b1;
            end
            OP_BEQ: begin
                ctrl_o.valid     = 1'b1;
                ctrl_o.use_rt    = 1'b1;
            end
            OP_ADDI: begin
                ctrl_o.valid     = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.dst_sel   = DST_RT;
            end
            OP_ANDI: begin
                ctrl_o.valid     = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.dst_sel   = DST_RT;
                imm_sel_o        = IMM_ZEXT;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - decode stage with register file, load-use hazard detect and ID/EX register
module id_stage_pipe
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       instr,
    input  logic [31:0]       pc_id,
    input  logic              nop_if,
    input  logic              stall_in,
    input  logic              flush,
    input  logic              wb_we,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              hazard_stall,
    output logic [DATA_W-1:0] rs_val,
    output logic [DATA_W-1:0] rt_val,
    output logic [DATA_W-1:0] imm_ext,
    output logic [31:0]       pc_ex,
    output logic [ADDR_W-1:0] rs_ex,
    output logic [ADDR_W-1:0] rt_ex,
    output logic [ADDR_W-1:0] dst_ex,
    output logic              mem_read,
    output logic              mem_write,
    output logic              reg_write,
    output logic              alu_src,
    output logic              nop_ex,
    output logic [CNT_W-1:0]  hazard_cnt
);

    localparam int NREG = 2 ** ADDR_W;

    typedef struct packed {
        logic [DATA_W-1:0] rs_val;
        logic [DATA_W-1:0] rt_val;
        logic [DATA_W-1:0] imm;
        logic [31:0]       pc;
        logic [ADDR_W-1:0] rs;
        logic [ADDR_W-1:0] rt;
        logic [ADDR_W-1:0] dst;
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
        logic              alu_src;
        logic              nop;
    } idex_t;

    logic [DATA_W-1:0] regs_q [NREG];
    idex_t             idex_q, idex_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    ctrl_t             ctrl;
    imm_sel_e          imm_sel;
    logic [ADDR_W-1:0] rs_a, rt_a, rd_a, dst_a;
    logic [DATA_W-1:0] rs_rd, rt_rd, imm_val;
    logic              dec_nop;

    id_decoder u_dec (
        .opcode_i  (instr[31:26]),
        .ctrl_o    (ctrl),
        .imm_sel_o (imm_sel)
    );

    assign rs_a = ADDR_W'(instr[25:21]);
    assign rt_a = ADDR_W'(instr[20:16]);
    assign rd_a = ADDR_W'(instr[15:11]);

    // Unknown opcodes travel down the pipe as bubbles, same as an IF bubble.
    assign dec_nop = nop_if | ~ctrl.valid;

    always_comb begin
        dst_a = '0;
        case (ctrl.dst_sel)
            DST_RT:  dst_a = rt_a;
            DST_RD:  dst_a = rd_a;
            default: dst_a = '0;
        endcase
    end

    assign imm_val = (imm_sel == IMM_ZEXT) ? {{(DATA_W-16){1'b0}}, instr[15:0]}
                                           : {{(DATA_W-16){instr[15]}}, instr[15:0]};

    // Reads see a same-cycle writeback so WB and ID can share a cycle.
    always_comb begin
        rs_rd = regs_q[rs_a];
        if (rs_a == '0)
            rs_rd = '0;
        else if (wb_we && (wb_addr == rs_a))
            rs_rd = wb_data;
    end

    always_comb begin
        rt_rd = regs_q[rt_a];
        if (rt_a == '0)
            rt_rd = '0;
        else if (wb_we && (wb_addr == rt_a))
            rt_rd = wb_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= '0;
        end else if (wb_we && (wb_addr != '0)) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    assign hazard_stall = idex_q.mem_read && !idex_q.nop && (idex_q.dst != '0) && !nop_if &&
                          ((ctrl.valid && (rs_a == idex_q.dst)) ||
                           (ctrl.use_rt && (rt_a == idex_q.dst)));

    always_comb begin
        idex_d = idex_q;
        cnt_d  = cnt_q;
        if (flush) begin
            idex_d     = '0;
            idex_d.nop = 1'b1;
        end else if (stall_in) begin
            idex_d = idex_q;
        end else if (hazard_stall) begin
            idex_d     = '0;
            idex_d.nop = 1'b1;
            idex_d.pc  = idex_q.pc;
            if (cnt_q != '1)
                cnt_d = cnt_q + CNT_W'(1);
        end else begin
            idex_d.rs_val    = rs_rd;
            idex_d.rt_val    = rt_rd;
            idex_d.imm       = imm_val;
            idex_d.pc        = pc_id;
            idex_d.rs        = rs_a;
            idex_d.rt        = rt_a;
            idex_d.dst       = dst_a;
            idex_d.mem_read  = ctrl.mem_read  & ~dec_nop;
            idex_d.mem_write = ctrl.mem_write & ~dec_nop;
            idex_d.reg_write = ctrl.reg_write & ~dec_nop;
            idex_d.alu_src   = ctrl.alu_src   & ~dec_nop;
            idex_d.nop       = dec_nop;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idex_q     <= '0;
            idex_q.nop <= 1'b1;
            cnt_q      <= '0;
        end else begin
            idex_q <= idex_d;
            cnt_q  <= cnt_d;
        end
    end

    assign rs_val     = idex_q.rs_val;
    assign rt_val     = idex_q.rt_val;
    assign imm_ext    = idex_q.imm;
    assign pc_ex      = idex_q.pc;
    assign rs_ex      = idex_q.rs;
    assign rt_ex      = idex_q.rt;
    assign dst_ex     = idex_q.dst;
    assign mem_read   = idex_q.mem_read;
    assign mem_write  = idex_q.mem_write;
    assign reg_write  = idex_q.reg_write;
    assign alu_src    = idex_q.alu_src;
    assign nop_ex     = idex_q.nop;
    assign hazard_cnt = cnt_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - directed vector bench for id_stage_pipe
module tb_id_stage_pipe;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instr, pc_id;
    logic        nop_if, stall_in, flush, wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    logic        hazard_stall, mem_read, mem_write, reg_write, alu_src, nop_ex;
    logic [31:0] rs_val, rt_val, imm_ext, pc_ex;
    logic [4:0]  rs_ex, rt_ex, dst_ex;
    logic [15:0] hazard_cnt;

    logic        hz2, mr2, mw2, rw2, as2, nop2;
    logic [31:0] rsv2, rtv2, imm2, pc2;
    logic [4:0]  rs2, rt2, dst2;
    logic [1:0]  cnt2;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    id_stage_pipe dut (
        .clock(clock), .reset(reset), .instr(instr), .pc_id(pc_id), .nop_if(nop_if),
        .stall_in(stall_in), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .hazard_stall(hazard_stall), .rs_val(rs_val), .rt_val(rt_val), .imm_ext(imm_ext),
        .pc_ex(pc_ex), .rs_ex(rs_ex), .rt_ex(rt_ex), .dst_ex(dst_ex), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .alu_src(alu_src), .nop_ex(nop_ex),
        .hazard_cnt(hazard_cnt)
    );

    id_stage_pipe #(.CNT_W(2)) dut_sat (
        .clock(clock), .reset(reset), .instr(instr), .pc_id(pc_id), .nop_if(nop_if),
        .stall_in(stall_in), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .hazard_stall(hz2), .rs_val(rsv2), .rt_val(rtv2), .imm_ext(imm2),
        .pc_ex(pc2), .rs_ex(rs2), .rt_ex(rt2), .dst_ex(dst2), .mem_read(mr2),
        .mem_write(mw2), .reg_write(rw2), .alu_src(as2), .nop_ex(nop2),
        .hazard_cnt(cnt2)
    );

    typedef struct {
        logic [31:0] instr, pc;
        logic        nop_if, stall, flush, wb_we;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        hz, nop, mr, mw, rw, as;
        logic [4:0]  rs, rt, dst;
        logic [31:0] rsv, rtv, imm, pcx;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'h00, rs, rt, rd, 11'h000};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic add(input logic [31:0] i, input logic [31:0] pc, input logic nif, input logic st, input logic fl,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic hz, input logic nop, input logic mr, input logic mw, input logic rw, input logic as,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                       input logic [31:0] rsv, input logic [31:0] rtv, input logic [31:0] imm, input logic [31:0] pcx,
                       input logic [15:0] cnt);
        vec_t v;
        v = '{i, pc, nif, st, fl, we, wa, wd, hz, nop, mr, mw, rw, as, rs, rt, dst, rsv, rtv, imm, pcx, cnt};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] pc, input logic nif, input logic st, input logic fl,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        instr = i; pc_id = pc; nop_if = nif; stall_in = st; flush = fl;
        wb_we = we; wb_addr = wa; wb_data = wd;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        step();
        step();
        chk("rst nop_ex", nop_ex, 1);
        chk("rst reg_write", reg_write, 0);
        chk("rst mem_read", mem_read, 0);
        chk("rst pc_ex", pc_ex, 0);
        chk("rst cnt", hazard_cnt, 0);
        chk("rst sat nop_ex", nop2, 1);
        reset = 1'b0;

        //   instr                       pc      nif st fl we wa  wd            hz nop mr mw rw as rs  rt  dst rsv           rtv           imm           pcx           cnt
        add(32'h0,                       32'h100, 1, 0, 0, 1, 1,  32'd5,        0, 1,  0, 0, 0, 0, 0,  0,  0,  32'h0,        32'h0,        32'h0,        32'h100,      0);
        add(32'h0,                       32'h104, 1, 0, 0, 1, 2,  32'd7,        0, 1,  0, 0, 0, 0, 0,  0,  0,  32'h0,        32'h0,        32'h0,        32'h104,      0);
        add(rtype(1, 2, 3),              32'h108, 0, 0, 0, 0, 0,  32'h0,        0, 0,  0, 0, 1, 0, 1,  2,  3,  32'd5,        32'd7,        32'h1800,     32'h108,      0);
        add(itype(6'h23, 1, 4, 16'h10),  32'h10C, 0, 0, 0, 0, 0,  32'h0,        0, 0,  1, 0, 1, 1, 1,  4,  4,  32'd5,        32'h0,        32'h10,       32'h10C,      0);
        add(rtype(4, 1, 5),              32'h110, 0, 0, 0, 0, 0,  32'h0,        1, 1,  0, 0, 0, 0, 0,  0,  0,  32'h0,        32'h0,        32'h0,        32'h10C,      1);
        add(rtype(4, 1, 5),              32'h110, 0, 0, 0, 0, 0,  32'h0,        0, 0,  0, 0, 1, 0, 4,  1,  5,  32'h0,        32'd5,        32'h2800,     32'h110,      1);
        add(itype(6'h08, 6, 7, 16'h1),   32'h114, 0, 0, 0, 1, 6,  32'hDEAD,     0, 0,  0, 0, 1, 1, 6,  7,  7,  32'hDEAD,     32'h0,        32'h1,        32'h114,      1);
        add(itype(6'h08, 0, 6, 16'h0),   32'h118, 0, 0, 0, 1, 0,  32'h1234,     0, 0,  0, 0, 1, 1, 0,  6,  6,  32'h0,        32'hDEAD,     32'h0,        32'h118,      1);
        add(itype(6'h08, 0, 8, 16'h0),   32'h11C, 0, 0, 0, 0, 0,  32'h0,        0, 0,  0, 0, 1, 1, 0,  8,  8,  32'h0,        32'h0,        32'h0,        32'h11C,      1);
        add(itype(6'h23, 1, 9, 16'h0),   32'h120, 0, 1, 1, 0, 0,  32'h0,        0, 1,  0, 0, 0, 0, 0,  0,  0,  32'h0,        32'h0,        32'h0,        32'h0,        1);
        add(itype(6'h23, 2, 9, 16'h4),   32'h124, 0, 0, 0, 0, 0,  32'h0,        0, 0,  1, 0, 1, 1, 2,  9,  9,  32'd7,        32'h0,        32'h4,        32'h124,      1);
        for (int k = 0; k < 3; k++)
            add(rtype(9, 3, 10),         32'h128, 0, 1, 0, 0, 0,  32'h0,        1, 0,  1, 0, 1, 1, 2,  9,  9,  32'd7,        32'h0,        32'h4,        32'h124,      1);
        add(itype(6'h0C, 1, 11, 16'h8000), 32'h12C, 0, 0, 0, 0, 0, 32'h0,       0, 0,  0, 0, 1, 1, 1,  11, 11, 32'd5,        32'h0,        32'h00008000, 32'h12C,      1);
        add(itype(6'h08, 1, 12, 16'h8000), 32'h130, 0, 0, 0, 0, 0, 32'h0,       0, 0,  0, 0, 1, 1, 1,  12, 12, 32'd5,        32'h0,        32'hFFFF8000, 32'h130,      1);
        add(itype(6'h2B, 2, 1, 16'h8),   32'h134, 0, 0, 0, 0, 0,  32'h0,        0, 0,  0, 1, 0, 1, 2,  1,  0,  32'd7,        32'd5,        32'h8,        32'h134,      1);
        add(itype(6'h3F, 1, 2, 16'h0),   32'h138, 0, 0, 0, 0, 0,  32'h0,        0, 1,  0, 0, 0, 0, 1,  2,  0,  32'd5,        32'd7,        32'h0,        32'h138,      1);
        add(itype(6'h23, 1, 0, 16'h0),   32'h13C, 0, 0, 0, 0, 0,  32'h0,        0, 0,  1, 0, 1, 1, 1,  0,  0,  32'd5,        32'h0,        32'h0,        32'h13C,      1);
        add(rtype(0, 0, 1),              32'h140, 0, 0, 0, 0, 0,  32'h0,        0, 0,  0, 0, 1, 0, 0,  0,  1,  32'h0,        32'h0,        32'h0800,     32'h140,      1);
        add(itype(6'h23, 2, 13, 16'h0),  32'h144, 0, 0, 0, 0, 0,  32'h0,        0, 0,  1, 0, 1, 1, 2,  13, 13, 32'd7,        32'h0,        32'h0,        32'h144,      1);
        add(itype(6'h08, 1, 13, 16'h2),  32'h148, 0, 0, 0, 0, 0,  32'h0,        0, 0,  0, 0, 1, 1, 1,  13, 13, 32'd5,        32'h0,        32'h2,        32'h148,      1);
        add(itype(6'h23, 1, 14, 16'h0),  32'h14C, 0, 0, 0, 0, 0,  32'h0,        0, 0,  1, 0, 1, 1, 1,  14, 14, 32'd5,        32'h0,        32'h0,        32'h14C,      1);
        add(itype(6'h2B, 2, 14, 16'h0),  32'h150, 0, 0, 0, 0, 0,  32'h0,        1, 1,  0, 0, 0, 0, 0,  0,  0,  32'h0,        32'h0,        32'h0,        32'h14C,      2);
        add(itype(6'h23, 1, 15, 16'h0),  32'h154, 0, 0, 0, 0, 0,  32'h0,        0, 0,  1, 0, 1, 1, 1,  15, 15, 32'd5,        32'h0,        32'h0,        32'h154,      2);
        add(rtype(15, 15, 1),            32'h158, 1, 0, 0, 0, 0,  32'h0,        0, 1,  0, 0, 0, 0, 15, 15, 1,  32'h0,        32'h0,        32'h0800,     32'h158,      2);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].instr, vecs[i].pc, vecs[i].nop_if, vecs[i].stall, vecs[i].flush,
                  vecs[i].wb_we, vecs[i].wb_addr, vecs[i].wb_data);
            @(negedge clock);
            chk($sformatf("v%0d hazard_stall", i), hazard_stall, vecs[i].hz);
            step();
            chk($sformatf("v%0d nop_ex", i), nop_ex, vecs[i].nop);
            chk($sformatf("v%0d mem_read", i), mem_read, vecs[i].mr);
            chk($sformatf("v%0d mem_write", i), mem_write, vecs[i].mw);
            chk($sformatf("v%0d reg_write", i), reg_write, vecs[i].rw);
            chk($sformatf("v%0d alu_src", i), alu_src, vecs[i].as);
            chk($sformatf("v%0d rs_ex", i), rs_ex, vecs[i].rs);
            chk($sformatf("v%0d rt_ex", i), rt_ex, vecs[i].rt);
            chk($sformatf("v%0d dst_ex", i), dst_ex, vecs[i].dst);
            chk($sformatf("v%0d rs_val", i), rs_val, vecs[i].rsv);
            chk($sformatf("v%0d rt_val", i), rt_val, vecs[i].rtv);
            chk($sformatf("v%0d imm_ext", i), imm_ext, vecs[i].imm);
            chk($sformatf("v%0d pc_ex", i), pc_ex, vecs[i].pcx);
            chk($sformatf("v%0d hazard_cnt", i), hazard_cnt, vecs[i].cnt);
        end

        // Five more load-use bubbles: wide counter keeps counting, 2-bit one pins at 3.
        for (int k = 1; k <= 5; k++) begin
            drive(itype(6'h23, 1, 4, 16'h0), 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
            step();
            drive(rtype(4, 1, 5), 32'h204, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
            @(negedge clock);
            chk($sformatf("sat%0d hazard_stall", k), hazard_stall, 1);
            step();
            chk($sformatf("sat%0d cnt16", k), hazard_cnt, 32'(2 + k));
            chk($sformatf("sat%0d cnt2", k), cnt2, (k >= 1) ? 32'd3 : 32'(2 + k));
        end

        drive(itype(6'h23, 1, 4, 16'h0), 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        step();
        chk("pre-reset mem_read", mem_read, 1);
        drive(rtype(4, 1, 5), 32'h304, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h99);
        reset = 1'b1;
        @(negedge clock);
        chk("mid reset hazard_stall", hazard_stall, 1);
        step();
        chk("mid reset nop_ex", nop_ex, 1);
        chk("mid reset mem_read", mem_read, 0);
        chk("mid reset pc_ex", pc_ex, 0);
        chk("mid reset dst_ex", dst_ex, 0);
        chk("mid reset cnt16", hazard_cnt, 0);
        chk("mid reset cnt2", cnt2, 0);
        reset = 1'b0;
        drive(rtype(1, 2, 3), 32'h308, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        step();
        chk("post reset rs_val", rs_val, 0);
        chk("post reset rt_val", rt_val, 0);
        chk("post reset nop_ex", nop_ex, 0);
        chk("post reset dst_ex", dst_ex, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
